// File: rtl/mrd_tlp_gen_pkg.sv
// Shared definitions for the MRd TLP generator: TLP/TRN constants, FSM encoding
// and the 3DW memory-read header builder.
package mrd_tlp_gen_pkg;

    localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
    localparam logic [4:0] TYPE_MRD       = 5'b00000;

    localparam logic [7:0] REM_ALL   = 8'h00;
    localparam logic [7:0] REM_UPPER = 8'h0F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HDR0 = 2'd2,
        ST_HDR1 = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] dw0;
        logic [31:0] dw1;
        logic [31:0] dw2;
    } mrd_hdr_t;

    // A length of 1024 DWs naturally truncates to a zero length field.
    function automatic mrd_hdr_t build_mrd32_hdr(
        input logic [10:0] len,
        input logic [15:0] req_id,
        input logic [7:0]  tag,
        input logic [31:0] addr
    );
        mrd_hdr_t   hdr;
        logic [3:0] last_be;
        last_be = (len == 11'd1) ? 4'h0 : 4'hF;
        hdr.dw0 = {1'b0, FMT_3DW_NODATA, TYPE_MRD, 14'h0000, len[9:0]};
        hdr.dw1 = {req_id, tag, last_be, 4'hF};
        hdr.dw2 = addr & 32'hFFFF_FFFC;
        return hdr;
    endfunction

endpackage

// File: rtl/mrd_tlp_gen_if.sv
// TX arbiter handshake plus TRN transmit bus between the MRd generator and the core.
interface mrd_tlp_gen_if;

    logic        req_o;
    logic        gnt_i;
    logic [63:0] trn_td_o;
    logic [7:0]  trn_trem_n_o;
    logic        trn_tsof_n_o;
    logic        trn_teof_n_o;
    logic        trn_tsrc_rdy_n_o;
    logic        trn_tdst_rdy_n_i;

    modport master (
        output req_o,
        output trn_td_o,
        output trn_trem_n_o,
        output trn_tsof_n_o,
        output trn_teof_n_o,
        output trn_tsrc_rdy_n_o,
        input  gnt_i,
        input  trn_tdst_rdy_n_i
    );

    modport slave (
        input  req_o,
        input  trn_td_o,
        input  trn_trem_n_o,
        input  trn_tsof_n_o,
        input  trn_teof_n_o,
        input  trn_tsrc_rdy_n_o,
        output gnt_i,
        output trn_tdst_rdy_n_i
    );

endinterface

// File: rtl/mrd_tlp_gen.sv
// DMA read-channel MRd request generator: issues 3DW MRd TLPs on the 64-bit TRN bus
// while the flow controller permits, and reports the running sent-TLP count.
module mrd_tlp_gen
    import mrd_tlp_gen_pkg::*;
#(
    parameter int TAG_WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_rst_i,
    input  logic              mrd_start_fc_i,
    input  logic [31:0]       mrd_addr_i,
    input  logic [10:0]       mrd_len_i,
    input  logic [15:0]       mrd_count_i,
    input  logic [15:0]       cfg_completer_id_i,
    mrd_tlp_gen_if.master     tx,
    output logic [31:0]       mrd_tlp_sent_o,
    output logic              mrd_done_o
);

    state_t                 state_reg;
    state_t                 state_next;
    mrd_hdr_t               hdr_reg;
    logic [TAG_WIDTH-1:0]   tag_reg;
    logic [31:0]            cur_addr_reg;
    logic [31:0]            sent_reg;
    logic                   done_reg;
    logic                   init_seen_reg;

    logic                   issue_ok;
    logic                   in_hdr;
    logic                   hdr1_accept;
    logic                   hdr_load;
    logic [7:0]             tag_field;

    assign tag_field   = 8'(tag_reg);
    assign issue_ok    = mrd_start_fc_i && (sent_reg[15:0] < mrd_count_i) && !init_rst_i;
    assign in_hdr      = (state_reg == ST_HDR0) || (state_reg == ST_HDR1);
    assign hdr1_accept = (state_reg == ST_HDR1) && !tx.trn_tdst_rdy_n_i;
    assign hdr_load    = (state_reg == ST_REQ) && (state_next == ST_HDR0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Once granted, a TLP always runs to EOF; only IDLE/REQ react to throttle or re-init.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (issue_ok) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (init_rst_i)           state_next = ST_IDLE;
                else if (tx.gnt_i)        state_next = ST_HDR0;
                else if (!mrd_start_fc_i) state_next = ST_IDLE;
            end
            ST_HDR0: begin
                if (!tx.trn_tdst_rdy_n_i) state_next = ST_HDR1;
            end
            ST_HDR1: begin
                if (!tx.trn_tdst_rdy_n_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx.req_o            = 1'b0;
        tx.trn_td_o         = 64'h0;
        tx.trn_trem_n_o     = REM_ALL;
        tx.trn_tsof_n_o     = 1'b1;
        tx.trn_teof_n_o     = 1'b1;
        tx.trn_tsrc_rdy_n_o = 1'b1;
        case (state_reg)
            ST_REQ: begin
                tx.req_o = 1'b1;
            end
            ST_HDR0: begin
                tx.req_o            = 1'b1;
                tx.trn_td_o         = {hdr_reg.dw0, hdr_reg.dw1};
                tx.trn_tsof_n_o     = 1'b0;
                tx.trn_tsrc_rdy_n_o = 1'b0;
            end
            ST_HDR1: begin
                tx.req_o            = 1'b1;
                tx.trn_td_o         = {hdr_reg.dw2, 32'h0};
                tx.trn_trem_n_o     = REM_UPPER;
                tx.trn_teof_n_o     = 1'b0;
                tx.trn_tsrc_rdy_n_o = 1'b0;
            end
            default: ;
        endcase
    end

    // The header is frozen at grant so a re-init reload cannot alter a TLP in flight;
    // init_seen_reg keeps that TLP from being counted against the new run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_reg       <= '0;
            tag_reg       <= '0;
            cur_addr_reg  <= 32'h0;
            sent_reg      <= 32'h0;
            done_reg      <= 1'b0;
            init_seen_reg <= 1'b0;
        end else begin
            if (init_rst_i) begin
                sent_reg     <= 32'h0;
                tag_reg      <= '0;
                cur_addr_reg <= mrd_addr_i;
            end else if (hdr1_accept && !init_seen_reg) begin
                sent_reg     <= sent_reg + 32'd1;
                tag_reg      <= tag_reg + TAG_WIDTH'(1);
                cur_addr_reg <= cur_addr_reg + {19'd0, mrd_len_i, 2'b00};
            end

            if (hdr1_accept) begin
                init_seen_reg <= 1'b0;
            end else if (init_rst_i && in_hdr) begin
                init_seen_reg <= 1'b1;
            end

            if (hdr_load) begin
                hdr_reg <= build_mrd32_hdr(mrd_len_i, cfg_completer_id_i, tag_field, cur_addr_reg);
            end

            done_reg <= (sent_reg[15:0] == mrd_count_i);
        end
    end

    assign mrd_tlp_sent_o = sent_reg;
    assign mrd_done_o     = done_reg;

endmodule

// File: tb/tb_mrd_tlp_gen.sv
// Scoreboard bench for mrd_tlp_gen: expected TLP headers are queued as runs are started
// and compared field by field when each TLP completes on the TRN bus.
module tb_mrd_tlp_gen;

    logic        clk;
    logic        rst_n;
    logic        init_rst_i;
    logic        mrd_start_fc_i;
    logic [31:0] mrd_addr_i;
    logic [10:0] mrd_len_i;
    logic [15:0] mrd_count_i;
    logic [15:0] cfg_completer_id_i;
    logic [31:0] mrd_tlp_sent_o;
    logic        mrd_done_o;
    logic        auto_gnt;

    mrd_tlp_gen_if tx_if ();

    mrd_tlp_gen #(.TAG_WIDTH(5)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .init_rst_i         (init_rst_i),
        .mrd_start_fc_i     (mrd_start_fc_i),
        .mrd_addr_i         (mrd_addr_i),
        .mrd_len_i          (mrd_len_i),
        .mrd_count_i        (mrd_count_i),
        .cfg_completer_id_i (cfg_completer_id_i),
        .tx                 (tx_if),
        .mrd_tlp_sent_o     (mrd_tlp_sent_o),
        .mrd_done_o         (mrd_done_o)
    );

    assign tx_if.gnt_i = auto_gnt & tx_if.req_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  tag;
        logic [10:0] len;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          sof_cyc[$];
    bit          rec_sof  = 0;
    logic [31:0] m_addr;
    logic [7:0]  m_tag;
    logic [63:0] hdr01;
    logic [7:0]  sof_rem;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_hdr01(input exp_t e);
        logic [31:0] dw0;
        logic [31:0] dw1;
        dw0 = {1'b0, 2'b00, 5'b00000, 14'h0, e.len[9:0]};
        dw1 = {cfg_completer_id_i, e.tag, (e.len == 11'd1) ? 4'h0 : 4'hF, 4'hF};
        return {dw0, dw1};
    endfunction

    task automatic model_init();
        m_addr = mrd_addr_i;
        m_tag  = 8'd0;
    endtask

    task automatic push_tlps(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = m_addr;
            e.tag  = m_tag;
            e.len  = mrd_len_i;
            sb.push_back(e);
            $display("push tlp addr=%08h tag=%0d len=%0d", e.addr, e.tag, e.len);
            m_addr = m_addr + {19'd0, mrd_len_i, 2'b00};
            m_tag  = (m_tag + 8'd1) % 8'd32;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sb_empty(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) chk("sb_timeout", sb.size(), 0);
    endtask

    task automatic wait_sof(input int budget);
        int n;
        n = 0;
        while (tx_if.trn_tsof_n_o !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        if (tx_if.trn_tsof_n_o !== 1'b0) chk("sof_timeout", tx_if.trn_tsof_n_o, 0);
    endtask

    task automatic wait_eof(input int budget);
        int n;
        n = 0;
        while (tx_if.trn_teof_n_o !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        if (tx_if.trn_teof_n_o !== 1'b0) chk("eof_timeout", tx_if.trn_teof_n_o, 0);
    endtask

    task automatic init_pulse();
        init_rst_i = 1'b1;
        tick();
        init_rst_i = 1'b0;
        model_init();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one line per completed TLP, checked against the scoreboard head.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] x;
        if (rst_n && !tx_if.trn_tsrc_rdy_n_o && !tx_if.trn_tdst_rdy_n_i) begin
            if (!tx_if.trn_tsof_n_o) begin
                hdr01   = tx_if.trn_td_o;
                sof_rem = tx_if.trn_trem_n_o;
                if (rec_sof) sof_cyc.push_back(cyc);
            end
            if (!tx_if.trn_teof_n_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_tlp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    x = exp_hdr01(e);
                    $display("tlp addr=%08h tag=%0d dw0=%08h dw1=%08h", tx_if.trn_td_o[63:32],
                             hdr01[15:8], hdr01[63:32], hdr01[31:0]);
                    chk("dw0", hdr01[63:32], x[63:32]);
                    chk("req_id", hdr01[31:16], x[31:16]);
                    chk("tag", hdr01[15:8], x[15:8]);
                    chk("last_be", hdr01[7:4], x[7:4]);
                    chk("first_be", hdr01[3:0], 4'hF);
                    chk("sof_rem", sof_rem, 8'h00);
                    chk("addr", tx_if.trn_td_o[63:32], e.addr);
                    chk("pad_dw", tx_if.trn_td_o[31:0], 32'h0);
                    chk("eof_rem", tx_if.trn_trem_n_o, 8'h0F);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                  = 1'b0;
        init_rst_i             = 1'b0;
        mrd_start_fc_i         = 1'b0;
        mrd_addr_i             = 32'h0;
        mrd_len_i              = 11'd1;
        mrd_count_i            = 16'd0;
        cfg_completer_id_i     = 16'hABCD;
        auto_gnt               = 1'b1;
        tx_if.trn_tdst_rdy_n_i = 1'b0;
        m_addr                 = 32'h0;
        m_tag                  = 8'd0;

        // Reset state
        tick();
        tick();
        chk("rst_req", tx_if.req_o, 0);
        chk("rst_td", tx_if.trn_td_o, 64'h0);
        chk("rst_trem", tx_if.trn_trem_n_o, 8'h00);
        chk("rst_sof", tx_if.trn_tsof_n_o, 1);
        chk("rst_eof", tx_if.trn_teof_n_o, 1);
        chk("rst_src", tx_if.trn_tsrc_rdy_n_o, 1);
        chk("rst_sent", mrd_tlp_sent_o, 0);
        chk("rst_done", mrd_done_o, 0);
        rst_n = 1'b1;
        tick();
        chk("done_cnt0", mrd_done_o, 1);
        mrd_start_fc_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("cnt0_noreq", tx_if.req_o, 0);
        mrd_start_fc_i = 1'b0;

        // Basic run
        mrd_addr_i  = 32'h1000_0000;
        mrd_len_i   = 11'd32;
        mrd_count_i = 16'd3;
        init_pulse();
        push_tlps(3);
        rec_sof        = 1;
        mrd_start_fc_i = 1'b1;
        wait_sb_empty(100);
        for (int i = 0; i < 3; i++) tick();
        rec_sof = 0;
        chk("basic_sent", mrd_tlp_sent_o, 3);
        chk("basic_done", mrd_done_o, 1);
        chk("basic_req", tx_if.req_o, 0);
        chk("basic_nsof", sof_cyc.size(), 3);
        if (sof_cyc.size() >= 3) begin
            chk("spacing01", sof_cyc[1] - sof_cyc[0], 4);
            chk("spacing12", sof_cyc[2] - sof_cyc[1], 4);
        end
        mrd_start_fc_i = 1'b0;

        // Backpressure in HDR0
        mrd_count_i            = 16'd4;
        tx_if.trn_tdst_rdy_n_i = 1'b1;
        push_tlps(1);
        mrd_start_fc_i = 1'b1;
        wait_sof(20);
        for (int i = 0; i < 5; i++) begin
            chk("bp_sof", tx_if.trn_tsof_n_o, 0);
            chk("bp_td", tx_if.trn_td_o, exp_hdr01(sb[0]));
            chk("bp_sent", mrd_tlp_sent_o, 3);
            tick();
        end
        tx_if.trn_tdst_rdy_n_i = 1'b0;
        wait_sb_empty(20);
        mrd_start_fc_i = 1'b0;
        tick();
        tick();
        chk("bp_sent_after", mrd_tlp_sent_o, 4);

        // Throttle during HDR1: TLP completes, no new request
        mrd_count_i = 16'd6;
        push_tlps(1);
        mrd_start_fc_i = 1'b1;
        wait_eof(20);
        mrd_start_fc_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("thr_hdr1_req", tx_if.req_o, 0);
        end
        chk("thr_hdr1_sent", mrd_tlp_sent_o, 5);
        chk("thr_hdr1_sb", sb.size(), 0);

        // Throttle during REQ before grant
        auto_gnt       = 1'b0;
        mrd_start_fc_i = 1'b1;
        tick();
        chk("thr_req_up", tx_if.req_o, 1);
        mrd_start_fc_i = 1'b0;
        tick();
        chk("thr_req_down", tx_if.req_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("thr_req_nosof", tx_if.trn_tsof_n_o, 1);
        end
        auto_gnt = 1'b1;
        chk("thr_req_sent", mrd_tlp_sent_o, 5);

        // Length edges and tag wrap
        mrd_addr_i  = 32'h2000_0000;
        mrd_len_i   = 11'd1;
        mrd_count_i = 16'd1;
        init_pulse();
        push_tlps(1);
        mrd_start_fc_i = 1'b1;
        wait_sb_empty(20);
        mrd_start_fc_i = 1'b0;
        mrd_len_i   = 11'd1024;
        mrd_count_i = 16'd3;
        push_tlps(2);
        mrd_start_fc_i = 1'b1;
        wait_sb_empty(40);
        mrd_start_fc_i = 1'b0;
        mrd_len_i   = 11'd4;
        mrd_count_i = 16'd34;
        push_tlps(31);
        mrd_start_fc_i = 1'b1;
        wait_sb_empty(400);
        mrd_start_fc_i = 1'b0;
        tick();
        tick();
        chk("wrap_sent", mrd_tlp_sent_o, 34);
        chk("wrap_done", mrd_done_o, 1);

        // Re-init during HDR0
        mrd_addr_i  = 32'h3000_0000;
        mrd_len_i   = 11'd8;
        mrd_count_i = 16'd40;
        push_tlps(1);
        mrd_start_fc_i = 1'b1;
        wait_sof(20);
        mrd_start_fc_i = 1'b0;
        init_pulse();
        wait_sb_empty(20);
        tick();
        tick();
        chk("init_sent", mrd_tlp_sent_o, 0);
        chk("init_done", mrd_done_o, 0);
        mrd_count_i = 16'd2;
        push_tlps(2);
        mrd_start_fc_i = 1'b1;
        wait_sb_empty(40);
        mrd_start_fc_i = 1'b0;
        tick();
        tick();
        chk("init_run_sent", mrd_tlp_sent_o, 2);
        chk("init_run_done", mrd_done_o, 1);

        // Asynchronous reset while HDR1 is stalled
        mrd_count_i            = 16'd3;
        tx_if.trn_tdst_rdy_n_i = 1'b1;
        push_tlps(1);
        mrd_start_fc_i = 1'b1;
        wait_sof(20);
        tx_if.trn_tdst_rdy_n_i = 1'b0;
        tick();
        tx_if.trn_tdst_rdy_n_i = 1'b1;
        mrd_start_fc_i         = 1'b0;
        chk("arst_in_hdr1", tx_if.trn_teof_n_o, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_src", tx_if.trn_tsrc_rdy_n_o, 1);
        chk("arst_req", tx_if.req_o, 0);
        chk("arst_eof", tx_if.trn_teof_n_o, 1);
        chk("arst_td", tx_if.trn_td_o, 64'h0);
        chk("arst_sent", mrd_tlp_sent_o, 0);
        sb.delete();
        tx_if.trn_tdst_rdy_n_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_done", mrd_done_o, 0);
        chk("arst_idle_req", tx_if.req_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mrd_tlp_gen.md
# mrd_tlp_gen

Memory-read request generator for the endpoint DMA read channel. Consumes the throttled start level from the flow controller (`mrd_start_fc_i`), builds 3DW MRd TLP headers on the 64-bit TRN transmit bus, and returns the running sent-TLP count that the flow controller uses to compute outstanding non-posted requests. It sits between the flow controller and the TX arbiter/TRN interface of the PCIe core.

## Interface
- `TAG_WIDTH`, 5: tag bits used; tags wrap modulo 2^TAG_WIDTH.
- `clk` in 1: TRN clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `init_rst_i` in 1: synchronous DMA re-init pulse.
- `mrd_start_fc_i` in 1: level; TLP issue permitted while high.
- `mrd_addr_i` in 32: start byte address, DW-aligned.
- `mrd_len_i` in 11: DWs per TLP, 1..1024.
- `mrd_count_i` in 16: TLPs to issue this run.
- `cfg_completer_id_i` in 16: requester ID {bus, dev, func}.
- `req_o` out 1: TX arbiter request.
- `gnt_i` in 1: TX arbiter grant.
- `trn_td_o` out 64: TRN data.
- `trn_trem_n_o` out 8: TRN remainder.
- `trn_tsof_n_o`, `trn_teof_n_o`, `trn_tsrc_rdy_n_o` out 1 each: TRN framing.
- `trn_tdst_rdy_n_i` in 1: core ready, active-low.
- `mrd_tlp_sent_o` out 32: TLPs fully transferred since init.
- `mrd_done_o` out 1: sent count has reached `mrd_count_i`.

## Operation
- States: IDLE, REQ, HDR0, HDR1.
- **IDLE → REQ:** when `mrd_start_fc_i`=1 and `mrd_tlp_sent_o[15:0]` < `mrd_count_i` and `init_rst_i`=0. `req_o` asserts in REQ.
- **REQ → HDR0:** on `gnt_i`=1. `mrd_start_fc_i` dropping while in REQ returns to IDLE with `req_o`=0. A TLP already in HDR0/HDR1 is never aborted by `mrd_start_fc_i`.
- **HDR0 beat:** `trn_td_o` = {DW0, DW1}; `tsof_n`=0; `teof_n`=1; `trem_n`=8'h00.
- **HDR1 beat:** `trn_td_o` = {DW2, 32'h0}; `teof_n`=0; `trem_n`=8'h0F.
- A beat transfers when `trn_tsrc_rdy_n_o`=0 and `trn_tdst_rdy_n_i`=0. Data is held stable otherwise.
- **DW0:** fmt=2'b00, type=5'b00000, TC/TD/EP/attr=0, length=`mrd_len_i[9:0]` (1024 encodes as 0).
- **DW1:** {`cfg_completer_id_i`, {pad, tag}, lastBE, firstBE=4'hF}. lastBE=4'h0 if len=1, else 4'hF.
- **DW2:** {`cur_addr[31:2]`, 2'b00}.
- **On HDR1 accept:**
  - `mrd_tlp_sent_o`+1.
  - tag+1 (wraps).
  - `cur_addr` += `mrd_len_i`<<2, modulo 2^32. 4KB crossing is not checked; software guarantees it.
  - `req_o` deasserts.
  - → IDLE.
- **`init_rst_i` in IDLE/REQ:** `mrd_tlp_sent_o`=0, tag=0, `cur_addr`=`mrd_addr_i`, `req_o`=0, → IDLE.
- **`init_rst_i` in HDR0/HDR1:** packet completes unmodified (no truncation on TRN). Counter, tag and `cur_addr` are reloaded as above. The completing TLP is not counted.
- `mrd_done_o` = (`mrd_tlp_sent_o[15:0]` == `mrd_count_i`), registered. `mrd_count_i`=0 gives done=1 and no TLPs.

## Timing
- **Reset values:**
  - `req_o`=0.
  - `trn_td_o`=0.
  - `trn_trem_n_o`=8'h00.
  - `tsof_n`/`teof_n`/`tsrc_rdy_n`=1.
  - `mrd_tlp_sent_o`=0.
  - `mrd_done_o`=1 iff `mrd_count_i`=0 after first clock, else 0.
  - State=IDLE; tag=0; `cur_addr`=0.
- **Latencies:**
  - `mrd_start_fc_i` high at edge N → `req_o` high after N.
  - `gnt_i` at edge M → HDR0 presented after M.
  - Minimum TLP spacing is 4 cycles (IDLE, REQ, HDR0, HDR1) with `tdst_rdy_n` held low.
- `mrd_tlp_sent_o` updates on the edge that accepts HDR1. The flow controller sees it one cycle later; its pending limit carries the margin for this lag.
- `rst_n` low mid-packet: all TRN outputs go idle immediately. A truncated packet is acceptable because the core is reset too.

## Structure
- Shared package contents:
  - TLP fmt/type constants (MRD32).
  - TRN remainder constants (`REM_ALL`=8'h00, `REM_UPPER`=8'h0F).
  - State encoding.
  - Header-DW builder function.
- No sub-module. The single FSM plus datapath registers are sufficient.

## Test plan
- **Basic run:** addr=32'h1000_0000, len=32, count=3, `fc` held high, `tdst_rdy_n`=0 → 3 TLPs.
  - Addresses 0x1000_0000, 0x1000_0080, 0x1000_0100; tags 0,1,2; length field 32; trem 8'h0F on EOF.
  - `mrd_tlp_sent_o`=3, `mrd_done_o`=1.
- **Backpressure:** `tdst_rdy_n`=1 for 5 cycles during HDR0 → `trn_td_o`/`sof` held stable; count increments only after HDR1 accept.
- **Throttle:** drop `mrd_start_fc_i` while in HDR1 → that TLP completes and no new `req_o` is raised. Drop it in REQ before grant → `req_o` falls, no SOF.
- **Length edges:**
  - len=1 → firstBE=F, lastBE=0.
  - len=1024 → length field 0, address +4096.
  - Tag 31 → next tag 0.
- **`init_rst_i` mid-packet:** pulse during HDR0 → packet finishes with EOF; afterwards `mrd_tlp_sent_o`=0 and the next TLP uses `mrd_addr_i` with tag 0.
- **Async reset:** `rst_n` low during HDR1 → `tsrc_rdy_n`=1 and `req_o`=0 without waiting for a clock edge.
